// File: rtl/conv_row_buf_writer_pkg.sv
// conv_row_buf_writer_pkg: bank-index, state and address-width constants shared by the row-buffer read and write sides
package conv_row_buf_writer_pkg;
  localparam int ADR_W = 16;
  localparam logic [1:0] BANK_NONE = 2'd0;
  localparam logic [1:0] BANK1 = 2'd1;
  localparam logic [1:0] BANK2 = 2'd2;
  localparam logic [1:0] BANK3 = 2'd3;
  typedef enum logic [1:0] {ST_FILL, ST_FULL, ST_REFILL} state_e;
endpackage

// File: rtl/conv_row_buf_writer_row_bank_rotator.sv
// row_bank_rotator: row-to-bank mapping registers with fill-order and rotate updates
module row_bank_rotator
  import conv_row_buf_writer_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       fill_en,
  input  logic [1:0] fill_bank,
  input  logic       rot_en,
  input  logic       clr,
  output logic [1:0] row1_idx,
  output logic [1:0] row2_idx,
  output logic [1:0] row3_idx
);
  logic [1:0] r1_q, r2_q, r3_q, r1_d, r2_d, r3_d;
  // clear beats rotate; during fill, completing bank N publishes it as window row N
  always_comb begin
    r1_d = clr ? BANK_NONE : rot_en ? r2_q : (fill_en && fill_bank == BANK1) ? BANK1 : r1_q;
    r2_d = clr ? BANK_NONE : rot_en ? r3_q : (fill_en && fill_bank == BANK2) ? BANK2 : r2_q;
    r3_d = clr ? BANK_NONE : rot_en ? r1_q : (fill_en && fill_bank == BANK3) ? BANK3 : r3_q;
  end
  // mapping registers
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r1_q <= BANK_NONE;
      r2_q <= BANK_NONE;
      r3_q <= BANK_NONE;
    end else begin
      r1_q <= r1_d;
      r2_q <= r2_d;
      r3_q <= r3_d;
    end
  assign row1_idx = r1_q;
  assign row2_idx = r2_q;
  assign row3_idx = r3_q;
endmodule

// File: rtl/conv_row_buf_writer.sv
// conv_row_buf_writer: writes streamed image rows into three rotating row-buffer banks
module conv_row_buf_writer
  import conv_row_buf_writer_pkg::*;
#(
  parameter int pixels_in_row = 32,
  parameter int words_per_row = 8,
  parameter int rows_per_frame = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [pixels_in_row*8-1:0] in_pixels_32,
  output logic [ADR_W-1:0]           wr_adr,
  output logic [pixels_in_row*8-1:0] wr_pixels_32,
  output logic                       buf1_we,
  output logic                       buf2_we,
  output logic                       buf3_we,
  output logic [1:0]                 row1_buf_idx,
  output logic [1:0]                 row2_buf_idx,
  output logic [1:0]                 row3_buf_idx,
  output logic                       window_valid,
  input  logic                       window_release,
  output logic                       frame_done
);
  localparam int DW = pixels_in_row * 8;
  localparam int WC_W = words_per_row > 1 ? $clog2(words_per_row) : 1;
  localparam logic [WC_W-1:0] LAST_WORD = WC_W'(words_per_row - 1);
  localparam logic [15:0] LAST_ROW = 16'(rows_per_frame);
  state_e state_q, state_d;
  logic [WC_W-1:0] wcnt_q, wcnt_d;
  logic [15:0] rows_q, rows_d;
  logic done_q, done_d, valid_q, valid_d, fd_q, fd_d, we_q, we_d;
  logic [1:0] bank_q, bank_d;
  logic [ADR_W-1:0] adr_q, adr_d;
  logic [DW-1:0] pix_q, pix_d;
  logic accept, last, rel, frame_end;
  assign in_ready = !reset && state_q != ST_FULL;
  // handshake decode, counters, write-port staging and next state
  always_comb begin
    accept = in_valid && in_ready;
    last = accept && wcnt_q == LAST_WORD;
    rel = state_q == ST_FULL && valid_q && window_release;
    frame_end = rel && rows_q == LAST_ROW;
    wcnt_d = accept ? (last ? '0 : wcnt_q + WC_W'(1)) : wcnt_q;
    rows_d = frame_end ? '0 : last ? rows_q + 16'd1 : rows_q;
    done_d = last;
    valid_d = rel ? 1'b0 : (done_q && state_q == ST_FULL) ? 1'b1 : valid_q;
    fd_d = frame_end;
    we_d = accept;
    bank_d = !accept ? bank_q : state_q == ST_FILL ? rows_q[1:0] + 2'd1 : row3_buf_idx;
    adr_d = accept ? ADR_W'(wcnt_q) : adr_q;
    pix_d = accept ? in_pixels_32 : pix_q;
    state_d = state_q == ST_FULL ? (rel ? (frame_end ? ST_FILL : ST_REFILL) : ST_FULL)
            : (last && (state_q == ST_REFILL || rows_q == 16'd2)) ? ST_FULL : state_q;
  end
  // state, counter and write-port registers
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= ST_FILL;
      wcnt_q <= '0;
      rows_q <= '0;
      done_q <= 1'b0;
      valid_q <= 1'b0;
      fd_q <= 1'b0;
      we_q <= 1'b0;
      bank_q <= BANK_NONE;
      adr_q <= '0;
      pix_q <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q <= wcnt_d;
      rows_q <= rows_d;
      done_q <= done_d;
      valid_q <= valid_d;
      fd_q <= fd_d;
      we_q <= we_d;
      bank_q <= bank_d;
      adr_q <= adr_d;
      pix_q <= pix_d;
    end
  row_bank_rotator u_rot (
    .clk(clk),
    .reset(reset),
    .fill_en(done_q && rows_q <= 16'd3),
    .fill_bank(bank_q),
    .rot_en(rel),
    .clr(frame_end),
    .row1_idx(row1_buf_idx),
    .row2_idx(row2_buf_idx),
    .row3_idx(row3_buf_idx)
  );
  assign wr_adr = adr_q;
  assign wr_pixels_32 = pix_q;
  assign buf1_we = we_q && bank_q == BANK1;
  assign buf2_we = we_q && bank_q == BANK2;
  assign buf3_we = we_q && bank_q == BANK3;
  assign window_valid = valid_q;
  assign frame_done = fd_q;
endmodule

// File: tb/tb_conv_row_buf_writer.sv
// tb_conv_row_buf_writer: randomized scoreboard bench for the row-buffer writer
module tb_conv_row_buf_writer;
  localparam int PIR = 32, WPR = 2, RPF = 4, DW = PIR * 8;
  logic clk = 0, reset = 1, in_valid = 0, window_release = 0;
  logic [DW-1:0] in_pixels_32 = '0;
  logic in_ready, buf1_we, buf2_we, buf3_we, window_valid, frame_done;
  logic [15:0] wr_adr;
  logic [DW-1:0] wr_pixels_32;
  logic [1:0] row1_buf_idx, row2_buf_idx, row3_buf_idx;

  conv_row_buf_writer #(.pixels_in_row(PIR), .words_per_row(WPR), .rows_per_frame(RPF)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_pixels_32(in_pixels_32), .wr_adr(wr_adr), .wr_pixels_32(wr_pixels_32),
    .buf1_we(buf1_we), .buf2_we(buf2_we), .buf3_we(buf3_we),
    .row1_buf_idx(row1_buf_idx), .row2_buf_idx(row2_buf_idx), .row3_buf_idx(row3_buf_idx),
    .window_valid(window_valid), .window_release(window_release), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] bank;
    logic [15:0] adr;
    logic [DW-1:0] data;
  } wr_t;
  wr_t sb[$];
  int n_cmp = 0, n_bad = 0;

  // reference model: visible window map, rows completed in frame, word position in row
  logic exp_ready, vvalid, exp_fd;
  logic [1:0] vmap[1:3];
  int m_rows, m_word;
  logic p_on, p_win;
  logic [1:0] p_fill;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h want=%0h @%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] rnd();
    logic [DW-1:0] r;
    for (int i = 0; i < DW / 32; i++) r[i*32+:32] = $urandom;
    return r;
  endfunction

  task automatic model_reset();
    exp_ready = 1; vvalid = 0; exp_fd = 0;
    foreach (vmap[i]) vmap[i] = 2'd0;
    m_rows = 0; m_word = 0; p_on = 0; p_win = 0; p_fill = 0;
    sb.delete();
  endtask

  // one cycle: check visible outputs, drive inputs, advance the model to the next cycle
  task automatic step(input logic v, input logic [DW-1:0] d, input logic rel);
    logic [1:0] bank, t;
    logic o_on, o_win;
    logic [1:0] o_fill;
    wr_t e;
    @(negedge clk);
    chk("in_ready", in_ready, exp_ready);
    chk("row1_idx", row1_buf_idx, vmap[1]);
    chk("row2_idx", row2_buf_idx, vmap[2]);
    chk("row3_idx", row3_buf_idx, vmap[3]);
    chk("window_valid", window_valid, vvalid);
    chk("frame_done", frame_done, exp_fd);
    in_valid = v; in_pixels_32 = d; window_release = rel;
    exp_fd = 0;
    o_on = p_on; o_win = p_win; o_fill = p_fill; p_on = 0;
    if (exp_ready && v) begin
      bank = m_rows < 3 ? 2'(m_rows + 1) : vmap[3];
      e.bank = bank; e.adr = 16'(m_word); e.data = d;
      sb.push_back(e);
      m_word++;
      if (m_word == WPR) begin
        m_word = 0;
        m_rows++;
        p_on = 1; p_fill = m_rows <= 3 ? bank : 2'd0; p_win = m_rows >= 3;
        if (m_rows >= 3) exp_ready = 0;
      end
    end else if (rel && vvalid) begin
      t = vmap[1]; vmap[1] = vmap[2]; vmap[2] = vmap[3]; vmap[3] = t;
      vvalid = 0; exp_ready = 1;
      if (m_rows == RPF) begin
        foreach (vmap[i]) vmap[i] = 2'd0;
        m_rows = 0;
        exp_fd = 1;
      end
    end
    if (o_on) begin
      if (o_fill != 0) vmap[o_fill] = o_fill;
      if (o_win) vvalid = 1;
    end
  endtask

  // write monitor: every bank write must match the oldest expected write
  always @(negedge clk) begin
    wr_t e;
    int nwe;
    nwe = int'(buf1_we) + int'(buf2_we) + int'(buf3_we);
    if (nwe != 0) begin
      chk("one_we", DW'(nwe), DW'(1));
      if (sb.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_write we=%b%b%b adr=%0d want=none @%0t", buf1_we, buf2_we, buf3_we, wr_adr, $time);
      end else begin
        e = sb.pop_front();
        chk("wr_bank", DW'(buf1_we ? 1 : buf2_we ? 2 : 3), DW'(e.bank));
        chk("wr_adr", DW'(wr_adr), DW'(e.adr));
        chk("wr_data", wr_pixels_32, e.data);
      end
    end
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_we"}, {buf1_we, buf2_we, buf3_we}, 0);
    chk({tag, "_adr"}, wr_adr, 0);
    chk({tag, "_pix"}, wr_pixels_32, 0);
    chk({tag, "_idx"}, {row1_buf_idx, row2_buf_idx, row3_buf_idx}, 0);
    chk({tag, "_valid"}, window_valid, 0);
    chk({tag, "_fd"}, frame_done, 0);
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    chk_reset_outputs("rst");
    reset = 0;
    for (int i = 1; i <= 6; i++) step(1, DW'(i), i == 3);
    repeat (6) step(1, rnd(), 0);
    step(0, rnd(), 1);
    step(1, DW'(7), 1);
    step(1, DW'(8), 0);
    repeat (4) step(1, rnd(), 0);
    step(0, rnd(), 1);
    step(1, rnd(), 1);
    step(1, rnd(), 0);
    step(1, rnd(), 0);
    step(0, rnd(), 0);
    #2 reset = 1;
    #1 chk_reset_outputs("async");
    model_reset();
    @(negedge clk);
    reset = 0;
    for (int i = 0; i < 800; i++) step($urandom_range(0, 3) != 0, rnd(), $urandom_range(0, 4) == 0);
    repeat (3) step(0, rnd(), 0);
    chk("sb_drain", DW'(sb.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/conv_row_buf_writer.md
# conv_row_buf_writer

Write-side companion to the convolution BRAM read/slab handler. Accepts a stream of 32-pixel words from the input DMA, writes each image row into one of the three row-buffer BRAM banks (buf1..buf3), and maintains the rotating row→bank mapping (`row1/2/3_buf_idx`) that the read side uses to build its 3-row window. The block applies back-pressure while all three banks hold live rows. A bank is refilled only after the consumer releases the oldest row.

## Interface
Parameters:
- `pixels_in_row`, 32, pixels per stream word (8 bits each).
- `words_per_row`, 8, stream words per image row; must be ≥1 and ≤65536.
- `rows_per_frame`, 16, image rows per frame; must be ≥3.

Ports:
- `clk` in 1: the single clock.
- `reset` in 1: asynchronous, active-high.
- `in_valid` in 1: stream word valid.
- `in_ready` out 1: block accepts a word this cycle.
- `in_pixels_32` in `pixels_in_row*8`: stream word.
- `wr_adr` out 16: BRAM write address, shared by all banks.
- `wr_pixels_32` out `pixels_in_row*8`: BRAM write data, shared by all banks.
- `buf1_we`, `buf2_we`, `buf3_we` out 1 each: per-bank write enables; at most one is high in any cycle.
- `row1_buf_idx`, `row2_buf_idx`, `row3_buf_idx` out 2 each: bank (1..3) holding the window's top, middle and bottom row; 0 means none.
- `window_valid` out 1: all three mapped rows are completely written.
- `window_release` in 1: the consumer has finished with the top row.
- `frame_done` out 1: one-cycle pulse when the final window is released.

## Operation
- States: FILL, FULL, REFILL.
- **FILL**
  - `in_ready`=1. Rows 0, 1 and 2 are written to banks 1, 2 and 3 respectively.
  - When row k completes, `row(k+1)_buf_idx` is set to bank k+1.
  - When the third row completes, go to FULL.
- **FULL**
  - `in_ready`=0 and `window_valid`=1.
  - On `window_release`:
    - Rotate the mapping: row1←row2, row2←row3, row3←old row1 bank.
    - If `rows_written == rows_per_frame`: pulse `frame_done`, clear all idx registers to 0, reset counters, go to FILL.
    - Otherwise go to REFILL.
- **REFILL**
  - `in_ready`=1 and `window_valid`=0. Words are written to the `row3_buf_idx` bank.
  - When the row completes, go to FULL.
- Counters:
  - Word counter is `clog2(words_per_row)` bits, zero-extended to form `wr_adr`. Every row starts at address 0 and wraps to 0 after `words_per_row-1`.
  - Row counter `rows_written` is 16 bits. It increments on each completed row and never exceeds `rows_per_frame`.
- `window_release` is ignored outside FULL and while `window_valid`=0.
- A stream handshake (`in_valid` & `in_ready`) in a cycle where `in_ready`=0 cannot occur. Data presented while `in_ready`=0 is not consumed.
- Reset mid-row or mid-frame discards all progress. Partially written bank contents are simply overwritten later.

## Timing
- Reset values: state FILL, all idx 0, `window_valid` 0, `frame_done` 0, all `we` 0, `wr_adr` 0, `wr_pixels_32` 0. `in_ready` is 0 while `reset` is asserted and 1 in the first cycle after deassertion.
- Write latency: a word accepted at cycle t appears on `wr_adr`/`wr_pixels_32`/`bufN_we` at t+1, registered and held for one cycle.
- Row completion: last word accepted at t, written at t+1. The idx update and `window_valid` rise at t+2, so the read side never sees a bank before its final write lands.
- `in_ready` is a combinational decode of the state register only, with no path from `in_valid`. It drops at t+1 after the last word of a row.
- Release at cycle t in FULL: the rotated idx, `window_valid`=0 and `in_ready`=1 all appear at t+1. `frame_done`, when applicable, is high for the single cycle t+1.
- Throughput: 1 word/cycle within a row. Minimum FULL→REFILL→FULL turnaround is `words_per_row`+2 cycles.

## Structure
- Shared conv package holds:
  - the bank-index constants `BANK_NONE`=0, `BANK1`..`BANK3`;
  - the state encoding;
  - the 16-bit address width constant. The read handler reuses the same constants.
- One sub-module: `row_bank_rotator`, which holds the three idx registers plus the fill-order and rotate logic.
- Counters, FSM and write-port registers stay in the top level.

## Test plan
- **Cold fill:** reset, stream 3×`words_per_row` words (params 2/4) with values 1..6.
  - Banks 1, 2, 3 each receive adr 0,1 = {1,2}, {3,4}, {5,6}.
  - idx 1/2/3; `window_valid` rises 2 cycles after word 6 is accepted.
- **Back-pressure:** hold `in_valid`=1 after the window fills.
  - `in_ready`=0 and no `we` pulses until `window_release`.
- **Rotation:** release, then stream row 3.
  - idx becomes 2/3/1; `buf1_we` is written with adr 0,1; `window_valid` returns.
  - A second release plus row 4 gives 3/1/2.
- **Frame end:** with `rows_per_frame`=4, release after row 3 is loaded.
  - `frame_done` pulses one cycle; idx 0/0/0; the next word goes to bank 1 adr 0.
- **Ignored release:** pulse `window_release` during FILL and during REFILL.
  - No mapping change, no `frame_done`.
- **Async reset mid-row:** assert `reset` between clock edges after 1 word of row 1.
  - All outputs go to reset values immediately; the next row restarts at bank 1 adr 0.
